// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared encodings for the load/store unit.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses instead of truncating them.
package ysyx_22041211_lsu_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SB   = 2'b01,
        ST_SH   = 2'b10,
        ST_SW   = 2'b11
    } store_e;

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_LB   = 3'b001,
        LD_LH   = 3'b010,
        LD_LW   = 3'b011,
        LD_LBU  = 3'b100,
        LD_LHU  = 3'b101
    } load_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DONE
    } state_e;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MISALIGN_CHECK = 1'b1;
`else
    localparam bit MISALIGN_CHECK = 1'b0;
`endif

    function automatic logic misaligned(store_e st, load_e ld, logic [1:0] off);
        logic half, word;
        half = (st == ST_SH) || (ld == LD_LH) || (ld == LD_LHU);
        word = (st == ST_SW) || (ld == LD_LW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Combinational lane steering: store mask/data placement and load extract/extend.
module ysyx_22041211_lsu_align
    import ysyx_22041211_lsu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  store_e              st_type,
    input  logic [1:0]          st_off,
    input  logic [DATA_LEN-1:0] st_data,
    output logic [3:0]          wmask,
    output logic [DATA_LEN-1:0] wdata,
    input  load_e               ld_type,
    input  logic [1:0]          ld_off,
    input  logic [DATA_LEN-1:0] rdata,
    output logic [DATA_LEN-1:0] ld_data
);

    logic [DATA_LEN-1:0] sh_b, sh_h;
    logic [7:0]          b;
    logic [15:0]         h;

    always_comb begin
        wmask = 4'b0000;
        wdata = '0;
        case (st_type)
            ST_SB: begin
                wmask = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            ST_SH: begin
                wmask = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            ST_SW: begin
                wmask = 4'b1111;
                wdata = st_data;
            end
            default: ;
        endcase
    end

    // Half selection only looks at off[1]; the odd-byte bit is dropped.
    assign sh_b = rdata >> {ld_off, 3'b000};
    assign sh_h = rdata >> {ld_off[1], 4'b0000};
    assign b    = sh_b[7:0];
    assign h    = sh_h[15:0];

    always_comb begin
        ld_data = '0;
        case (ld_type)
            LD_LB:   ld_data = {{(DATA_LEN-8){b[7]}}, b};
            LD_LBU:  ld_data = {{(DATA_LEN-8){1'b0}}, b};
            LD_LH:   ld_data = {{(DATA_LEN-16){h[15]}}, h};
            LD_LHU:  ld_data = {{(DATA_LEN-16){1'b0}}, h};
            LD_LW:   ld_data = rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: valid/ready from execute, req/rsp to data memory, valid/ready to write-back.
// Optional LSU_MISALIGN_CHECK_EN adds misalign_o and skips the bus for misaligned accesses.
module ysyx_22041211_lsu
    import ysyx_22041211_lsu_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ADDR_LEN-1:0] alu_result_i,
    input  logic [DATA_LEN-1:0] store_data_i,
    input  logic [1:0]          store_type_i,
    input  logic [2:0]          load_type_i,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic                mem_wen_o,
    output logic [3:0]          mem_wmask_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic                wb_wd_o,
    output logic [4:0]          wb_wreg_o,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic                misalign_o,
`endif
    output logic [DATA_LEN-1:0] wb_wdata_o
);

    state_e              state, state_nxt;
    load_e               ld_q;
    logic [1:0]          off_q;
    store_e              st_in;
    load_e               ld_in;
    logic                is_mem, mis_in;
    logic [3:0]          st_mask;
    logic [DATA_LEN-1:0] st_wdata, ld_data;

    // A store wins over a simultaneous load; the load half is dropped.
    assign st_in  = store_e'(store_type_i);
    assign ld_in  = (st_in != ST_NONE) ? LD_NONE : load_e'(load_type_i);
    assign is_mem = (st_in != ST_NONE) || (ld_in != LD_NONE);
    assign mis_in = MISALIGN_CHECK && misaligned(st_in, ld_in, alu_result_i[1:0]);

    assign in_ready_o = (state == S_IDLE);

    ysyx_22041211_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
        .st_type (st_in),
        .st_off  (alu_result_i[1:0]),
        .st_data (store_data_i),
        .wmask   (st_mask),
        .wdata   (st_wdata),
        .ld_type (ld_q),
        .ld_off  (off_q),
        .rdata   (mem_rdata_i),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (in_valid_i) state_nxt = (is_mem && !mis_in) ? S_REQ : S_DONE;
            S_REQ:      if (mem_req_ready_i) state_nxt = S_WAIT_RSP;
            S_WAIT_RSP: if (mem_rsp_valid_i) state_nxt = S_DONE;
            S_DONE:     if (wb_ready_i) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q            <= LD_NONE;
            off_q           <= 2'b00;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_wen_o       <= 1'b0;
            mem_wmask_o     <= 4'b0000;
            mem_wdata_o     <= '0;
            wb_valid_o      <= 1'b0;
            wb_wd_o         <= 1'b0;
            wb_wreg_o       <= 5'd0;
            wb_wdata_o      <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid_i) begin
                    ld_q        <= ld_in;
                    off_q       <= alu_result_i[1:0];
                    wb_wd_o     <= wd_i && (st_in == ST_NONE) && !mis_in;
                    wb_wreg_o   <= wreg_i;
                    mem_addr_o  <= {alu_result_i[ADDR_LEN-1:2], 2'b00};
                    mem_wen_o   <= (st_in != ST_NONE);
                    mem_wmask_o <= st_mask;
                    mem_wdata_o <= st_wdata;
                    if (is_mem && !mis_in) begin
                        mem_req_valid_o <= 1'b1;
                    end else begin
                        wb_valid_o <= 1'b1;
                        wb_wdata_o <= is_mem ? '0 : DATA_LEN'(alu_result_i);
                    end
                end
                S_REQ:      if (mem_req_ready_i) mem_req_valid_o <= 1'b0;
                S_WAIT_RSP: if (mem_rsp_valid_i) begin
                    wb_valid_o <= 1'b1;
                    wb_wdata_o <= ld_data;
                end
                S_DONE:     if (wb_ready_i) wb_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                                  misalign_o <= 1'b0;
        else if (state == S_IDLE && in_valid_i)   misalign_o <= mis_in;
        else if (state == S_DONE && wb_ready_i)   misalign_o <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Scoreboard bench for the LSU: expected bus requests and write-back results are queued at issue.
module tb_ysyx_22041211_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] alu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic [1:0]  store_type_i = '0;
    logic [2:0]  load_type_i = '0;
    logic        wd_i = 1'b0;
    logic [4:0]  wreg_i = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rsp_valid_i = 1'b1;
    logic [31:0] mem_rdata_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b1;
    logic        wb_wd_o;
    logic [4:0]  wb_wreg_o;
    logic [31:0] wb_wdata_o;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    ysyx_22041211_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .store_type_i(store_type_i), .load_type_i(load_type_i),
        .wd_i(wd_i), .wreg_i(wreg_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
`ifdef LSU_MISALIGN_CHECK_EN
        .misalign_o(misalign_o),
`endif
        .wb_wdata_o(wb_wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wd;
        logic [4:0]  wreg;
        logic [31:0] data;
        logic        chk_data;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  mask;
        logic [31:0] data;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_wb(input logic wd, input logic [4:0] wreg, input logic [31:0] data, input logic chk_data);
        wb_t e;
        e.wd = wd; e.wreg = wreg; e.data = data; e.chk_data = chk_data;
        wb_q.push_back(e);
    endtask

    task automatic push_req(input logic [31:0] addr, input logic wen, input logic [3:0] mask, input logic [31:0] data);
        req_t e;
        e.addr = addr; e.wen = wen; e.mask = mask; e.data = data;
        req_q.push_back(e);
    endtask

    // Monitors: pop on every observed handshake.
    always @(negedge clk) begin : mon
        wb_t  we;
        req_t re;
        if (!rst) begin
            if (wb_valid_o && wb_ready_i) begin
                if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
                else begin
                    we = wb_q.pop_front();
                    check("wb_wd", {31'd0, wb_wd_o}, {31'd0, we.wd});
                    check("wb_wreg", {27'd0, wb_wreg_o}, {27'd0, we.wreg});
                    if (we.chk_data) check("wb_wdata", wb_wdata_o, we.data);
                end
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                if (req_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
                else begin
                    re = req_q.pop_front();
                    check("req_addr", mem_addr_o, re.addr);
                    check("req_wen", {31'd0, mem_wen_o}, {31'd0, re.wen});
                    if (re.wen) begin
                        check("req_wmask", {28'd0, mem_wmask_o}, {28'd0, re.mask});
                        check("req_wdata", mem_wdata_o, re.data);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] addr, input logic [31:0] sdata, input logic [1:0] st,
                        input logic [2:0] ld, input logic wd, input logic [4:0] wreg);
        int n = 0;
        in_valid_i = 1'b1; alu_result_i = addr; store_data_i = sdata;
        store_type_i = st; load_type_i = ld; wd_i = wd; wreg_i = wreg;
        while (!in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid_i = 1'b0; store_type_i = '0; load_type_i = '0; wd_i = 1'b0;
    endtask

    // Cycles (counted at falling edges) from accept until wb_valid_o is seen.
    task automatic wait_wb(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_valid_o && lat < 30);
        if (!wb_valid_o) check("wb_timeout", 32'd1, 32'd0);
    endtask

    task automatic finish_wb();
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wb_wdata", wb_wdata_o, 32'd0);
        @(posedge clk); #1;

        // Non-memory op
        push_wb(1'b1, 5'd5, 32'h0000_1234, 1'b1);
        send(32'h0000_1234, 32'h0, 2'b00, 3'b000, 1'b1, 5'd5);
        wait_wb(lat);
        check("nonmem_lat", lat, 32'd1);
        check("nonmem_no_req", {31'd0, mem_req_valid_o}, 32'd0);
        finish_wb();

        // sb at offset 3
        push_req(32'h8000_0000, 1'b1, 4'b1000, 32'hABAB_ABAB);
        push_wb(1'b0, 5'd7, 32'h0, 1'b0);
        send(32'h8000_0003, 32'h0000_00AB, 2'b01, 3'b000, 1'b1, 5'd7);
        wait_wb(lat);
        check("sb_lat", lat, 32'd3);
        finish_wb();

        // Loads with immediate bus
        mem_rdata_i = 32'h0080_0000;
        push_req(32'h8000_0000, 1'b0, 4'b0, 32'h0);
        push_wb(1'b1, 5'd3, 32'hFFFF_FF80, 1'b1);
        send(32'h8000_0002, 32'h0, 2'b00, 3'b001, 1'b1, 5'd3);
        wait_wb(lat);
        check("lb_lat", lat, 32'd3);
        finish_wb();

        push_req(32'h8000_0000, 1'b0, 4'b0, 32'h0);
        push_wb(1'b1, 5'd4, 32'h0000_0080, 1'b1);
        send(32'h8000_0002, 32'h0, 2'b00, 3'b100, 1'b1, 5'd4);
        wait_wb(lat); finish_wb();

        mem_rdata_i = 32'hBEEF_0000;
        push_req(32'h0000_0100, 1'b0, 4'b0, 32'h0);
        push_wb(1'b1, 5'd8, 32'h0000_BEEF, 1'b1);
        send(32'h0000_0102, 32'h0, 2'b00, 3'b101, 1'b1, 5'd8);
        wait_wb(lat); finish_wb();

        mem_rdata_i = 32'h8001_0000;
        push_req(32'h0000_0000, 1'b0, 4'b0, 32'h0);
        push_wb(1'b1, 5'd9, 32'hFFFF_8001, 1'b1);
        send(32'h0000_0002, 32'h0, 2'b00, 3'b010, 1'b1, 5'd9);
        wait_wb(lat); finish_wb();

        mem_rdata_i = 32'hDEAD_BEEF;
        push_req(32'h0000_0004, 1'b0, 4'b0, 32'h0);
        push_wb(1'b1, 5'd10, 32'hDEAD_BEEF, 1'b1);
        send(32'h0000_0004, 32'h0, 2'b00, 3'b011, 1'b1, 5'd10);
        wait_wb(lat); finish_wb();

        // sh upper half, sw, and illegal store+load (store wins)
        push_req(32'h0000_0004, 1'b1, 4'b1100, 32'h5678_5678);
        push_wb(1'b0, 5'd11, 32'h0, 1'b0);
        send(32'h0000_0006, 32'h1234_5678, 2'b10, 3'b000, 1'b1, 5'd11);
        wait_wb(lat); finish_wb();

        push_req(32'h0000_0008, 1'b1, 4'b1111, 32'hCAFE_F00D);
        push_wb(1'b0, 5'd12, 32'h0, 1'b0);
        send(32'h0000_0008, 32'hCAFE_F00D, 2'b11, 3'b000, 1'b1, 5'd12);
        wait_wb(lat); finish_wb();

        push_req(32'h0000_000C, 1'b1, 4'b1111, 32'h1357_9BDF);
        push_wb(1'b0, 5'd13, 32'h0, 1'b0);
        send(32'h0000_000C, 32'h1357_9BDF, 2'b11, 3'b011, 1'b1, 5'd13);
        wait_wb(lat); finish_wb();

        // Backpressure on both the bus request and write-back
        mem_req_ready_i = 1'b0;
        wb_ready_i = 1'b0;
        push_req(32'h0000_0100, 1'b1, 4'b1100, 32'h5678_5678);
        push_wb(1'b0, 5'd6, 32'h0, 1'b0);
        send(32'h0000_0102, 32'h1234_5678, 2'b10, 3'b000, 1'b1, 5'd6);
        repeat (3) begin
            @(negedge clk);
            check("bp_req_valid", {31'd0, mem_req_valid_o}, 32'd1);
            check("bp_addr", mem_addr_o, 32'h0000_0100);
            check("bp_wmask", {28'd0, mem_wmask_o}, 32'h0000_000C);
            check("bp_wdata", mem_wdata_o, 32'h5678_5678);
            check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
        end
        @(posedge clk); #1 mem_req_ready_i = 1'b1;
        wait_wb(lat);
        repeat (2) begin
            @(negedge clk);
            check("bp_wb_valid", {31'd0, wb_valid_o}, 32'd1);
            check("bp_wb_wreg", {27'd0, wb_wreg_o}, 32'd6);
            check("bp_wb_wd", {31'd0, wb_wd_o}, 32'd0);
            check("bp_wb_in_ready", {31'd0, in_ready_o}, 32'd0);
        end
        @(posedge clk); #1 wb_ready_i = 1'b1;
        finish_wb();

`ifdef LSU_MISALIGN_CHECK_EN
        push_wb(1'b0, 5'd14, 32'h0, 1'b0);
        send(32'h8000_0002, 32'h0, 2'b00, 3'b011, 1'b1, 5'd14);
        wait_wb(lat);
        check("mis_lat", lat, 32'd1);
        check("mis_flag", {31'd0, misalign_o}, 32'd1);
        check("mis_no_req", {31'd0, mem_req_valid_o}, 32'd0);
        finish_wb();
        @(negedge clk);
        check("mis_clear", {31'd0, misalign_o}, 32'd0);
        @(posedge clk); #1;
`else
        // Misaligned word and half accesses are truncated
        mem_rdata_i = 32'h1122_3344;
        push_req(32'h8000_0000, 1'b0, 4'b0, 32'h0);
        push_wb(1'b1, 5'd14, 32'h1122_3344, 1'b1);
        send(32'h8000_0002, 32'h0, 2'b00, 3'b011, 1'b1, 5'd14);
        wait_wb(lat);
        check("trunc_lw_lat", lat, 32'd3);
        finish_wb();
        push_req(32'h0000_0004, 1'b1, 4'b1100, 32'hA5A5_A5A5);
        push_wb(1'b0, 5'd15, 32'h0, 1'b0);
        send(32'h0000_0007, 32'h0000_A5A5, 2'b10, 3'b000, 1'b1, 5'd15);
        wait_wb(lat); finish_wb();
`endif

        // Reset while waiting for the response; late response must be ignored
        mem_rsp_valid_i = 1'b0;
        push_req(32'h0000_0020, 1'b0, 4'b0, 32'h0);
        send(32'h0000_0020, 32'h0, 2'b00, 3'b011, 1'b1, 5'd9);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rsp_valid_i = 1'b1;
        @(negedge clk);
        check("mrst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("mrst_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
        check("mrst_addr", mem_addr_o, 32'd0);
        check("mrst_wen", {31'd0, mem_wen_o}, 32'd0);
        check("mrst_wb_wreg", {27'd0, wb_wreg_o}, 32'd0);
        check("mrst_wb_wd", {31'd0, wb_wd_o}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mrst_no_wb", {31'd0, wb_valid_o}, 32'd0);
        end

        repeat (3) @(negedge clk);
        check("wb_q_empty", wb_q.size(), 32'd0);
        check("req_q_empty", req_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
